// File: rtl/strela_csr_bank.sv
// CSR bank configuring the CGRA memory nodes: channel descriptors, run control and status.
// Bus reads are combinational and always ready; control pulses and irq come from flops.
package strela_csr_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module strela_csr_bank #(
  parameter type         reg_req_t = strela_csr_pkg::reg_req_t,
  parameter type         reg_rsp_t = strela_csr_pkg::reg_rsp_t,
  parameter int unsigned IN_N      = 4,
  parameter int unsigned OUT_N     = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  reg_req_t                  reg_req_i,
  output reg_rsp_t                  reg_rsp_o,
  output logic [IN_N-1:0][31:0]     data_input_addr_o,
  output logic [IN_N-1:0][15:0]     data_input_size_o,
  output logic [IN_N-1:0][15:0]     data_input_stride_o,
  output logic [OUT_N-1:0][31:0]    data_output_addr_o,
  output logic [OUT_N-1:0][15:0]    data_output_size_o,
  input  logic [OUT_N-1:0]          out_done_i,
  output logic                      execute_o,
  output logic                      reset_state_machines_o,
  output logic                      irq_o
);

  localparam logic [31:0] INFO = {8'(OUT_N), 8'(IN_N), 16'h5354};

  function automatic logic [31:0] merge_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  logic [IN_N-1:0][31:0]  in_addr_q, in_addr_d;
  logic [IN_N-1:0][15:0]  in_size_q, in_size_d, in_stride_q, in_stride_d;
  logic [OUT_N-1:0][31:0] out_addr_q, out_addr_d;
  logic [OUT_N-1:0][15:0] out_size_q, out_size_d;
  logic [OUT_N-1:0]       seen_q, seen_d, size_nz;
  logic [31:0]            cycles_q, cycles_d, rdata, merged;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, irq_en_q, irq_en_d;
  logic execute_q, execute_d, srst_q, srst_d, irq_q, irq_d;
  logic hit, desc_hit, pending;

  logic [11:0] a;
  logic        wr, ctrl_wr, stat_wr, start, soft_rst;
  logic [31:0] wdata;
  logic        unused_addr;

  assign a           = reg_req_i.addr[11:0];
  assign wdata       = reg_req_i.wdata;
  assign wr          = reg_req_i.valid & reg_req_i.write;
  assign ctrl_wr     = wr && (a[11:2] == 10'd0);
  assign stat_wr     = wr && (a[11:2] == 10'd1);
  assign start       = ctrl_wr & wdata[0];
  assign soft_rst    = ctrl_wr & wdata[1];
  assign unused_addr = ^{reg_req_i.addr[31:12], a[1:0]};

  // Address decode, read mux and descriptor updates (dropped while a run is active).
  always_comb begin
    in_addr_d   = in_addr_q;
    in_size_d   = in_size_q;
    in_stride_d = in_stride_q;
    out_addr_d  = out_addr_q;
    out_size_d  = out_size_q;
    rdata       = '0;
    merged      = '0;
    hit         = 1'b0;
    desc_hit    = 1'b0;
    if (a[11:4] == 8'h00) begin
      hit = 1'b1;
      case (a[3:2])
        2'd0:    rdata = {29'd0, irq_en_q, 2'b00};
        2'd1:    rdata = {29'd0, err_q, done_q, busy_q};
        2'd2:    rdata = cycles_q;
        default: rdata = INFO;
      endcase
    end
    for (int i = 0; i < IN_N; i++) begin
      if (a[11:8] == 4'h1 && a[7:3] == 5'(i)) begin
        hit      = 1'b1;
        desc_hit = 1'b1;
        if (a[2]) begin
          rdata  = {in_stride_q[i], in_size_q[i]};
          merged = merge_strb(rdata, wdata, reg_req_i.wstrb);
          if (wr && !busy_q) {in_stride_d[i], in_size_d[i]} = merged;
        end else begin
          rdata  = in_addr_q[i];
          merged = merge_strb(rdata, wdata, reg_req_i.wstrb);
          if (wr && !busy_q) in_addr_d[i] = merged;
        end
      end
    end
    for (int j = 0; j < OUT_N; j++) begin
      if (a[11:8] == 4'h2 && a[7:3] == 5'(j)) begin
        hit      = 1'b1;
        desc_hit = 1'b1;
        rdata    = a[2] ? {16'd0, out_size_q[j]} : out_addr_q[j];
        merged   = merge_strb(rdata, wdata, reg_req_i.wstrb);
        if (wr && !busy_q) begin
          if (a[2]) out_size_d[j] = merged[15:0];
          else      out_addr_d[j] = merged;
        end
      end
    end
  end

  always_comb begin
    for (int j = 0; j < OUT_N; j++) size_nz[j] = (out_size_q[j] != 16'd0);
  end
  assign pending = |(size_nz & ~seen_q);

  // Run control; hardware sets of done/err are applied after W1C so they win.
  always_comb begin
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    seen_d    = seen_q | (out_done_i & {OUT_N{busy_q}});
    cycles_d  = (busy_q && cycles_q != 32'hFFFF_FFFF) ? cycles_q + 32'd1 : cycles_q;
    irq_en_d  = ctrl_wr ? wdata[2] : irq_en_q;
    execute_d = 1'b0;
    srst_d    = 1'b0;
    if (stat_wr) begin
      if (wdata[2]) err_d  = 1'b0;
      if (wdata[1]) done_d = 1'b0;
    end
    if (wr && desc_hit && busy_q) err_d = 1'b1;
    if (soft_rst) begin
      srst_d = 1'b1;
      busy_d = 1'b0;
      seen_d = '0;
    end else begin
      if (start && busy_q) err_d = 1'b1;
      if (start && !busy_q) begin
        execute_d = 1'b1;
        busy_d    = 1'b1;
        cycles_d  = '0;
        seen_d    = '0;
        done_d    = 1'b0;
      end
      if (busy_q && !pending) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
    irq_d = done_d & irq_en_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < IN_N; i++)  in_addr_q[i]  <= 32'h8000_0000 + (32'(i) << 24);
      for (int j = 0; j < OUT_N; j++) out_addr_q[j] <= 32'h9000_0000 + (32'(j) << 24);
      in_size_q   <= '0;
      in_stride_q <= '0;
      out_size_q  <= '0;
      seen_q      <= '0;
      cycles_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      irq_en_q    <= 1'b0;
      execute_q   <= 1'b0;
      srst_q      <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      in_addr_q   <= in_addr_d;
      in_size_q   <= in_size_d;
      in_stride_q <= in_stride_d;
      out_addr_q  <= out_addr_d;
      out_size_q  <= out_size_d;
      seen_q      <= seen_d;
      cycles_q    <= cycles_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      irq_en_q    <= irq_en_d;
      execute_q   <= execute_d;
      srst_q      <= srst_d;
      irq_q       <= irq_d;
    end
  end

  always_comb begin
    reg_rsp_o       = '0;
    reg_rsp_o.rdata = rdata;
    reg_rsp_o.error = reg_req_i.valid & ~hit;
    reg_rsp_o.ready = 1'b1;
  end

  assign data_input_addr_o      = in_addr_q;
  assign data_input_size_o      = in_size_q;
  assign data_input_stride_o    = in_stride_q;
  assign data_output_addr_o     = out_addr_q;
  assign data_output_size_o     = out_size_q;
  assign execute_o              = execute_q;
  assign reset_state_machines_o = srst_q;
  assign irq_o                  = irq_q;

endmodule

// File: tb/tb_strela_csr_bank.sv
// Bench for strela_csr_bank: constant vector table, random descriptor traffic against a
// register-image model, and hand-written run/abort/reset sequences.
module tb_strela_csr_bank;
  import strela_csr_pkg::*;

  localparam int IN_N  = 4;
  localparam int OUT_N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  reg_req_t req;
  reg_rsp_t rsp;
  logic [IN_N-1:0][31:0]  in_addr;
  logic [IN_N-1:0][15:0]  in_size, in_stride;
  logic [OUT_N-1:0][31:0] out_addr;
  logic [OUT_N-1:0][15:0] out_size;
  logic [OUT_N-1:0]       out_done;
  logic execute, srst, irq;

  int n_chk = 0, n_fail = 0, exec_cnt = 0, srst_cnt = 0;

  strela_csr_bank #(.IN_N(IN_N), .OUT_N(OUT_N)) dut (
    .clk_i(clk), .rst_ni(rst_n), .reg_req_i(req), .reg_rsp_o(rsp),
    .data_input_addr_o(in_addr), .data_input_size_o(in_size), .data_input_stride_o(in_stride),
    .data_output_addr_o(out_addr), .data_output_size_o(out_size), .out_done_i(out_done),
    .execute_o(execute), .reset_state_machines_o(srst), .irq_o(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (execute) exec_cnt++;
    if (srst) srst_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference: a word-indexed image of the descriptor space, written byte by byte.
  logic [31:0] img [0:1023];

  function automatic bit is_desc(input logic [31:0] ad);
    return (ad >= 32'h100 && ad < 32'h100 + 32'(8*IN_N)) ||
           (ad >= 32'h200 && ad < 32'h200 + 32'(8*OUT_N));
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 1024; w++) img[w] = 32'h0;
    for (int i = 0; i < IN_N; i++)  img[(32'h100 + 8*i) / 4] = 32'h8000_0000 + 32'h0100_0000 * i;
    for (int i = 0; i < OUT_N; i++) img[(32'h200 + 8*i) / 4] = 32'h9000_0000 + 32'h0100_0000 * i;
  endtask

  task automatic model_write(input logic [31:0] ad, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    if (is_desc(ad)) begin
      v = img[ad[11:2]];
      for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
      if (ad >= 32'h200 && ad[2]) v = v & 32'h0000_FFFF;
      img[ad[11:2]] = v;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] ad, input logic [31:0] d, input logic [3:0] s,
                           output logic e);
    @(negedge clk);
    req.addr = ad; req.write = 1'b1; req.wdata = d; req.wstrb = s; req.valid = 1'b1;
    #1 e = rsp.error;
    @(posedge clk);
    #1 req.valid = 1'b0; req.write = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] ad, output logic [31:0] d, output logic e);
    @(negedge clk);
    req.addr = ad; req.write = 1'b0; req.valid = 1'b1;
    #1 d = rsp.rdata; e = rsp.error;
    req.valid = 1'b0;
  endtask

  task automatic wr(input logic [31:0] ad, input logic [31:0] d);
    logic e;
    bus_write(ad, d, 4'hF, e);
    model_write(ad, d, 4'hF);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] ad, input logic [31:0] exp);
    logic [31:0] d;
    logic e;
    bus_read(ad, d, e);
    check(name, d, exp);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        do_wr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] ad, input logic w, input logic [31:0] d,
                              input logic [3:0] s, input logic [31:0] x, input logic xe);
    vec_t v;
    v.addr = ad; v.do_wr = w; v.wdata = d; v.wstrb = s; v.exp_rd = x; v.exp_err = xe;
    return v;
  endfunction

  initial begin
    vec_t vt [17];
    logic [31:0] d, ad;
    logic e;
    int snap_e, snap_s;

    vt[0]  = mk(32'h100, 0, 0, 0, 32'h8000_0000, 0);
    vt[1]  = mk(32'h108, 0, 0, 0, 32'h8100_0000, 0);
    vt[2]  = mk(32'h204, 0, 0, 0, 32'h0000_0000, 0);
    vt[3]  = mk(32'h004, 0, 0, 0, 32'h0000_0000, 0);
    vt[4]  = mk(32'h00C, 0, 0, 0, 32'h0404_5354, 0);
    vt[5]  = mk(32'h000, 0, 0, 0, 32'h0000_0000, 0);
    vt[6]  = mk(32'h008, 0, 0, 0, 32'h0000_0000, 0);
    vt[7]  = mk(32'h218, 0, 0, 0, 32'h9300_0000, 0);
    vt[8]  = mk(32'h104, 1, 32'h0004_0050, 4'b0011, 32'h0000_0050, 0);
    vt[9]  = mk(32'h10C, 1, 32'hFFFF_FFFF, 4'b1100, 32'hFFFF_0000, 0);
    vt[10] = mk(32'h204, 1, 32'hFFFF_1234, 4'b1111, 32'h0000_1234, 0);
    vt[11] = mk(32'h300, 1, 32'h1234_5678, 4'b1111, 32'h0000_0000, 1);
    vt[12] = mk(32'h120, 0, 0, 0, 32'h0000_0000, 1);
    vt[13] = mk(32'h000, 1, 32'h0000_0004, 4'b1111, 32'h0000_0004, 0);
    vt[14] = mk(32'h208, 1, 32'hABCD_EF01, 4'b0101, 32'h91CD_0001, 0);
    vt[15] = mk(32'h010, 0, 0, 0, 32'h0000_0000, 1);
    vt[16] = mk(32'h00C, 1, 32'hFFFF_FFFF, 4'b1111, 32'h0404_5354, 0);

    req = '0;
    out_done = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check("rst_exec", 32'(execute), 0);
    check("rst_srst", 32'(srst), 0);
    check("rst_irq", 32'(irq), 0);
    @(negedge clk) rst_n = 1'b1;

    for (int k = 0; k < 17; k++) begin
      if (vt[k].do_wr) begin
        bus_write(vt[k].addr, vt[k].wdata, vt[k].wstrb, e);
        check($sformatf("vec%0d_werr", k), 32'(e), 32'(vt[k].exp_err));
        model_write(vt[k].addr, vt[k].wdata, vt[k].wstrb);
      end
      bus_read(vt[k].addr, d, e);
      check($sformatf("vec%0d_rdata", k), d, vt[k].exp_rd);
      check($sformatf("vec%0d_rerr", k), 32'(e), 32'(vt[k].exp_err));
    end

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0:       ad = 32'h100 + 32'(4 * $urandom_range(0, 2*IN_N - 1));
        1:       ad = 32'h200 + 32'(4 * $urandom_range(0, 2*OUT_N - 1));
        2:       ad = 32'h100 + 32'(4 * $urandom_range(0, 63));
        default: ad = 32'(4 * $urandom_range(4, 1023));
      endcase
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        snap_e = int'($urandom_range(0, 15));
        bus_write(ad, d, 4'(snap_e), e);
        check($sformatf("rnd_werr@%03h", ad), 32'(e), 32'(!is_desc(ad)));
        model_write(ad, d, 4'(snap_e));
      end else begin
        bus_read(ad, d, e);
        check($sformatf("rnd_rd@%03h", ad), d, is_desc(ad) ? img[ad[11:2]] : 32'h0);
        check($sformatf("rnd_rerr@%03h", ad), 32'(e), 32'(!is_desc(ad)));
      end
    end

    // Run with one pending output: done arrives 10 cycles after the start write.
    wr(32'h204, 32'd80); wr(32'h20C, 0); wr(32'h214, 0); wr(32'h21C, 0);
    snap_e = exec_cnt;
    bus_write(32'h000, 32'h5, 4'hF, e);
    check("run_exec_hi", 32'(execute), 1);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k == 1) check("run_exec_lo", 32'(execute), 0);
    end
    out_done = 4'b0001;
    @(posedge clk); #1 out_done = '0;
    rd_chk("run_busy", 32'h004, 32'h1);
    @(posedge clk);
    rd_chk("run_done", 32'h004, 32'h2);
    rd_chk("run_cycles", 32'h008, 32'd11);
    check("run_irq", 32'(irq), 1);
    check("run_pulses", 32'(exec_cnt - snap_e), 1);
    bus_write(32'h004, 32'h2, 4'hF, e);
    rd_chk("w1c_done", 32'h004, 32'h0);
    check("w1c_irq", 32'(irq), 0);

    // All output sizes zero, irq disabled: a single busy cycle and no interrupt.
    wr(32'h204, 0);
    bus_write(32'h000, 32'h1, 4'hF, e);
    rd_chk("zero_busy", 32'h004, 32'h1);
    @(posedge clk);
    rd_chk("zero_done", 32'h004, 32'h2);
    rd_chk("zero_cycles", 32'h008, 32'd1);
    check("zero_irq", 32'(irq), 0);

    // Start and descriptor writes while busy are refused and flag err.
    wr(32'h20C, 32'd5);
    snap_e = exec_cnt;
    bus_write(32'h000, 32'h1, 4'hF, e);
    rd_chk("busy_status", 32'h004, 32'h1);
    bus_write(32'h000, 32'h1, 4'hF, e);
    repeat (2) @(posedge clk);
    rd_chk("busy_start_err", 32'h004, 32'h5);
    check("busy_pulses", 32'(exec_cnt - snap_e), 1);
    bus_write(32'h004, 32'h4, 4'hF, e);
    rd_chk("w1c_err", 32'h004, 32'h1);
    bus_write(32'h100, 32'hDEAD_BEEF, 4'hF, e);
    rd_chk("busy_desc_err", 32'h004, 32'h5);
    rd_chk("busy_desc_kept", 32'h100, img[32'h100 / 4]);
    bus_write(32'h004, 32'h4, 4'hF, e);

    // Soft reset mid-run.
    snap_s = srst_cnt;
    bus_write(32'h000, 32'h2, 4'hF, e);
    check("srst_hi", 32'(srst), 1);
    @(posedge clk); #1 check("srst_lo", 32'(srst), 0);
    rd_chk("srst_status", 32'h004, 32'h0);
    rd_chk("srst_desc", 32'h20C, img[32'h20C / 4]);
    check("srst_pulses", 32'(srst_cnt - snap_s), 1);

    // Soft reset and start together: soft reset wins.
    snap_e = exec_cnt;
    snap_s = srst_cnt;
    bus_write(32'h000, 32'h3, 4'hF, e);
    repeat (2) @(posedge clk);
    check("both_exec", 32'(exec_cnt - snap_e), 0);
    check("both_srst", 32'(srst_cnt - snap_s), 1);
    rd_chk("both_status", 32'h004, 32'h0);

    // Asynchronous reset in the middle of a run.
    bus_write(32'h000, 32'h1, 4'hF, e);
    rd_chk("arst_pre", 32'h004, 32'h1);
    @(negedge clk);
    req.addr = 32'h004; req.write = 1'b0; req.valid = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("arst_status", rsp.rdata, 32'h0);
    check("arst_size", 32'(out_size[1]), 0);
    check("arst_addr", in_addr[0], 32'h8000_0000);
    req.valid = 1'b0;
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    rd_chk("arst_cycles", 32'h008, 32'h0);
    rd_chk("arst_desc", 32'h20C, img[32'h20C / 4]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
